// File: rtl/rvh_l1d_plru_mp.sv
// Tree pseudo-LRU replacement state for a set-associative L1D with multiple hit-touch ports
// and a registered victim request/response handshake.
module rvh_l1d_plru_mp #(
    parameter int ENTRY_NUM    = 64,
    parameter int WAY_NUM      = 8,
    parameter int HIT_PORT_NUM = 2,
    localparam int SET_W = $clog2(ENTRY_NUM),
    localparam int WAY_W = $clog2(WAY_NUM),
    localparam int LRU_W = WAY_NUM - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [HIT_PORT_NUM-1:0]       hit_vld,
    input  logic [HIT_PORT_NUM*SET_W-1:0] hit_set,
    input  logic [HIT_PORT_NUM*WAY_W-1:0] hit_way,
    input  logic                          vic_req_vld,
    output logic                          vic_req_rdy,
    input  logic [SET_W-1:0]              vic_req_set,
    input  logic [WAY_NUM-1:0]            vic_req_valid,
    input  logic [WAY_NUM-1:0]            vic_req_lock,
    output logic                          vic_resp_vld,
    input  logic                          vic_resp_rdy,
    output logic [WAY_W-1:0]              vic_resp_way,
    output logic                          vic_resp_none
);

    logic [LRU_W-1:0] plru_q [ENTRY_NUM];
    logic [LRU_W-1:0] plru_d [ENTRY_NUM];

    logic             vic_acc_p0;
    logic [LRU_W-1:0] sel_lru_p0;
    logic [WAY_W-1:0] sel_way_p0;
    logic             sel_none_p0;
    logic             inv_found_p0;
    logic [WAY_W-1:0] inv_way_p0;

    // Heap node n lives at bit n-1; every node on the path is pointed away from the touched way.
    function automatic logic [LRU_W-1:0] plru_touch(input logic [LRU_W-1:0] lru,
                                                    input logic [WAY_W-1:0] way);
        logic [LRU_W-1:0] res;
        logic             b;
        int               node;
        res  = lru;
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b = way[WAY_W-1-lvl];
            for (int k = 0; k < LRU_W; k++) begin
                if (k == node - 1) res[k] = ~b;
            end
            node = 2 * node + int'(b);
        end
        return res;
    endfunction

    // Follow the LRU pointer unless that child subtree is fully locked. Caller guarantees
    // at least one unlocked way, so the chosen side always contains one.
    function automatic logic [WAY_W-1:0] plru_pick(input logic [LRU_W-1:0] lru,
                                                   input logic [WAY_NUM-1:0] lock);
        logic [WAY_W-1:0] way;
        logic             dir;
        logic             l_all;
        logic             r_all;
        int               node;
        int               prefix;
        way  = '0;
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            prefix = node - (1 << lvl);
            l_all  = 1'b1;
            r_all  = 1'b1;
            for (int w = 0; w < WAY_NUM; w++) begin
                if (((w >> (WAY_W - 1 - lvl)) == 2 * prefix) && !lock[w]) l_all = 1'b0;
                if (((w >> (WAY_W - 1 - lvl)) == 2 * prefix + 1) && !lock[w]) r_all = 1'b0;
            end
            dir = 1'b0;
            for (int k = 0; k < LRU_W; k++) begin
                if (k == node - 1) dir = lru[k];
            end
            if (!dir && l_all) dir = 1'b1;
            else if (dir && r_all) dir = 1'b0;
            way[WAY_W-1-lvl] = dir;
            node = 2 * node + int'(dir);
        end
        return way;
    endfunction

    assign vic_req_rdy = !vic_resp_vld || vic_resp_rdy;
    assign vic_acc_p0  = vic_req_vld && vic_req_rdy;

    always_comb begin
        sel_lru_p0   = plru_q[vic_req_set];
        inv_found_p0 = 1'b0;
        inv_way_p0   = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (!vic_req_valid[w] && !vic_req_lock[w]) begin
                inv_found_p0 = 1'b1;
                inv_way_p0   = WAY_W'(w);
            end
        end
        sel_none_p0 = &vic_req_lock;
        if (sel_none_p0) sel_way_p0 = '0;
        else if (inv_found_p0) sel_way_p0 = inv_way_p0;
        else sel_way_p0 = plru_pick(sel_lru_p0, vic_req_lock);
    end

    // Hit touches compose in port order, then the victim touch, then flush wipes everything.
    always_comb begin
        plru_d = plru_q;
        for (int p = 0; p < HIT_PORT_NUM; p++) begin
            if (hit_vld[p]) begin
                plru_d[hit_set[p*SET_W +: SET_W]] =
                    plru_touch(plru_d[hit_set[p*SET_W +: SET_W]], hit_way[p*WAY_W +: WAY_W]);
            end
        end
        if (vic_acc_p0 && !sel_none_p0) begin
            plru_d[vic_req_set] = plru_touch(plru_d[vic_req_set], sel_way_p0);
        end
        if (flush) begin
            for (int e = 0; e < ENTRY_NUM; e++) plru_d[e] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < ENTRY_NUM; e++) plru_q[e] <= '0;
        end else begin
            plru_q <= plru_d;
        end
    end

    // Response stage: single-entry skid, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vic_resp_vld  <= 1'b0;
            vic_resp_way  <= '0;
            vic_resp_none <= 1'b0;
        end else if (vic_acc_p0) begin
            vic_resp_vld  <= 1'b1;
            vic_resp_way  <= sel_way_p0;
            vic_resp_none <= sel_none_p0;
        end else if (vic_resp_rdy) begin
            vic_resp_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvh_l1d_plru_mp.sv
// Directed bench for rvh_l1d_plru_mp (4-way): expected victims are queued at request time
// and compared when the response handshake completes.
module tb_rvh_l1d_plru_mp;

    localparam int ENTRY_NUM    = 64;
    localparam int WAY_NUM      = 4;
    localparam int HIT_PORT_NUM = 2;
    localparam int SET_W        = $clog2(ENTRY_NUM);
    localparam int WAY_W        = $clog2(WAY_NUM);

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic [HIT_PORT_NUM-1:0]       hit_vld;
    logic [HIT_PORT_NUM*SET_W-1:0] hit_set;
    logic [HIT_PORT_NUM*WAY_W-1:0] hit_way;
    logic                          vic_req_vld;
    logic                          vic_req_rdy;
    logic [SET_W-1:0]              vic_req_set;
    logic [WAY_NUM-1:0]            vic_req_valid;
    logic [WAY_NUM-1:0]            vic_req_lock;
    logic                          vic_resp_vld;
    logic                          vic_resp_rdy;
    logic [WAY_W-1:0]              vic_resp_way;
    logic                          vic_resp_none;

    int tests = 0;
    int fails = 0;
    int hs    = 0;
    int hs0;
    logic [WAY_W:0] sbq [$];

    rvh_l1d_plru_mp #(
        .ENTRY_NUM   (ENTRY_NUM),
        .WAY_NUM     (WAY_NUM),
        .HIT_PORT_NUM(HIT_PORT_NUM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .hit_vld      (hit_vld),
        .hit_set      (hit_set),
        .hit_way      (hit_way),
        .vic_req_vld  (vic_req_vld),
        .vic_req_rdy  (vic_req_rdy),
        .vic_req_set  (vic_req_set),
        .vic_req_valid(vic_req_valid),
        .vic_req_lock (vic_req_lock),
        .vic_resp_vld (vic_resp_vld),
        .vic_resp_rdy (vic_resp_rdy),
        .vic_resp_way (vic_resp_way),
        .vic_resp_none(vic_resp_none)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any handshake seen at the falling edge, then move past the rising edge.
    task automatic tick();
        logic [WAY_W:0] e;
        @(negedge clk);
        if (vic_resp_vld && vic_resp_rdy) begin
            hs++;
            chk("sb_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("resp", {vic_resp_none, vic_resp_way}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [SET_W-1:0] set, input logic [WAY_NUM-1:0] valid,
                         input logic [WAY_NUM-1:0] lock, input logic [WAY_W-1:0] exp_way,
                         input logic exp_none);
        vic_req_vld   = 1'b1;
        vic_req_set   = set;
        vic_req_valid = valid;
        vic_req_lock  = lock;
        #0;
        chk("req_rdy", vic_req_rdy, 1);
        sbq.push_back({exp_none, exp_way});
        tick();
        vic_req_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; hit_vld = '0; hit_set = '0; hit_way = '0;
        vic_req_vld = 1'b0; vic_req_set = '0; vic_req_valid = '1; vic_req_lock = '0;
        vic_resp_rdy = 1'b1;
        #1;
        chk("rst_resp_vld", vic_resp_vld, 0);
        chk("rst_resp_way", vic_resp_way, 0);
        chk("rst_resp_none", vic_resp_none, 0);
        chk("rst_req_rdy", vic_req_rdy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Back-to-back round robin through the tree on set 0
        hs0 = hs;
        issue(6'd0, 4'b1111, 4'b0000, 2'd0, 1'b0);
        issue(6'd0, 4'b1111, 4'b0000, 2'd2, 1'b0);
        issue(6'd0, 4'b1111, 4'b0000, 2'd1, 1'b0);
        issue(6'd0, 4'b1111, 4'b0000, 2'd3, 1'b0);
        tick();
        chk("throughput_hs", hs - hs0, 4);
        chk("throughput_q", sbq.size(), 0);

        // Invalid ways take priority
        issue(6'd7, 4'b1011, 4'b0000, 2'd2, 1'b0);
        issue(6'd7, 4'b0000, 4'b0001, 2'd1, 1'b0);
        tick();

        // Locks, from a fresh reset
        rst = 1'b1; #1; rst = 1'b0;
        issue(6'd7, 4'b1111, 4'b0001, 2'd1, 1'b0);
        issue(6'd7, 4'b1111, 4'b1111, 2'd0, 1'b1);
        issue(6'd7, 4'b1111, 4'b0000, 2'd2, 1'b0);
        issue(6'd7, 4'b1111, 4'b0000, 2'd0, 1'b0);
        tick();

        // Two hit ports on one set: port 1 ends MRU
        hit_vld = 2'b11;
        hit_set = {6'd3, 6'd3};
        hit_way = {2'd0, 2'd2};
        tick();
        hit_vld = 2'b00;
        issue(6'd3, 4'b1111, 4'b0000, 2'd3, 1'b0);

        // Hit and victim on the same set in one cycle: victim touch applied last
        hit_vld = 2'b01;
        hit_set = {6'd0, 6'd5};
        hit_way = {2'd0, 2'd3};
        issue(6'd5, 4'b1111, 4'b0000, 2'd0, 1'b0);
        hit_vld = 2'b00;
        issue(6'd5, 4'b1111, 4'b0000, 2'd2, 1'b0);

        // Flush overrides same-cycle touches but the accepted response still arrives
        flush   = 1'b1;
        hit_vld = 2'b01;
        hit_set = {6'd0, 6'd5};
        hit_way = {2'd0, 2'd0};
        issue(6'd5, 4'b1111, 4'b0000, 2'd1, 1'b0);
        flush   = 1'b0;
        hit_vld = 2'b00;
        issue(6'd5, 4'b1111, 4'b0000, 2'd0, 1'b0);
        tick();

        // Consumer stall: response held, requests back-pressured
        vic_resp_rdy = 1'b0;
        issue(6'd0, 4'b1101, 4'b0000, 2'd1, 1'b0);
        vic_req_vld   = 1'b1;
        vic_req_set   = 6'd21;
        vic_req_valid = 4'b0111;
        vic_req_lock  = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req_rdy", vic_req_rdy, 0);
            chk("stall_resp_vld", vic_resp_vld, 1);
            chk("stall_resp", {vic_resp_none, vic_resp_way}, 3'b001);
        end
        hs0 = hs;
        vic_resp_rdy = 1'b1;
        #0;
        chk("release_req_rdy", vic_req_rdy, 1);
        sbq.push_back(3'b011);
        tick();
        vic_req_vld = 1'b0;
        chk("release_hs", hs - hs0, 1);
        tick();
        chk("release_q", sbq.size(), 0);

        // Async reset with a response pending
        vic_resp_rdy = 1'b0;
        issue(6'd3, 4'b1111, 4'b0000, 2'd1, 1'b0);
        chk("pre_rst_resp_vld", vic_resp_vld, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_resp_vld", vic_resp_vld, 0);
        chk("async_rst_resp_way", vic_resp_way, 0);
        sbq.delete();
        #1;
        rst = 1'b0;
        vic_resp_rdy = 1'b1;
        tick();
        issue(6'd3, 4'b1111, 4'b0000, 2'd0, 1'b0);
        tick();
        chk("final_q", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
